// File: rtl/data_sram_arb_pkg.sv
// Shared types and defaults for the data SRAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package data_sram_arb_pkg;

    // Which requester owns an in-flight read.
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    // One slot of the response tag pipeline.
    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rsp_tag_t;

    localparam int STARVE_MAX_DEF = 4;  // must fit the 3-bit starvation counter
    localparam int RD_LAT_DEF     = 1;  // legal range 1..3
    localparam int STARVE_W       = 3;

endpackage

// File: rtl/data_sram_arb_if.sv
// Bundle of the CPU/debug request+response signals and the data SRAM port.
// Latency: n/a (wiring only).
// Backpressure: requesters hold their request until the matching *_req_ready.
// Modports: slave = the arbiter; master = its environment (both requesters
// and the SRAM read-data return).
interface data_sram_arb_if;

    logic        cpu_req_valid;
    logic [3:0]  cpu_req_we;
    logic [31:0] cpu_req_addr;
    logic [31:0] cpu_req_wdata;
    logic        cpu_req_ready;

    logic        dbg_req_valid;
    logic [3:0]  dbg_req_we;
    logic [31:0] dbg_req_addr;
    logic [31:0] dbg_req_wdata;
    logic        dbg_req_ready;

    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    logic        cpu_rsp_valid;
    logic [31:0] cpu_rsp_rdata;
    logic        dbg_rsp_valid;
    logic [31:0] dbg_rsp_rdata;

    logic        cpu_stall;

    modport slave (
        input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
        input  dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata,
        input  sram_rdata,
        output cpu_req_ready, dbg_req_ready,
        output sram_en, sram_we, sram_addr, sram_wdata,
        output cpu_rsp_valid, cpu_rsp_rdata, dbg_rsp_valid, dbg_rsp_rdata,
        output cpu_stall
    );

    modport master (
        output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
        output dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata,
        output sram_rdata,
        input  cpu_req_ready, dbg_req_ready,
        input  sram_en, sram_we, sram_addr, sram_wdata,
        input  cpu_rsp_valid, cpu_rsp_rdata, dbg_rsp_valid, dbg_rsp_rdata,
        input  cpu_stall
    );

endinterface

// File: rtl/data_sram_arb_rsp_tag_pipe.sv
// Delay line carrying the owner of each SRAM read until its data returns.
// Latency: RD_LAT cycles from push_tag to tail_tag.
// Backpressure: none; advances every cycle, one tag per cycle.
// Ports: clk, reset (sync, active-high), push_tag (tag for this cycle's
// SRAM access, invalid for writes/idle), tail_tag (tag aligned to sram_rdata).
module rsp_tag_pipe
    import data_sram_arb_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic     clk,
    input  logic     reset,
    input  rsp_tag_t push_tag,
    output rsp_tag_t tail_tag
);

    rsp_tag_t slot [RD_LAT];

    // Clearing every slot on reset is what drops reads that were in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                slot[i] <= '0;
            end
        end else begin
            slot[0] <= push_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                slot[i] <= slot[i-1];
            end
        end
    end

    assign tail_tag = slot[RD_LAT-1];

endmodule

// File: rtl/data_sram_arb.sv
// Two-requester (CPU, debug) arbiter for a single-port data SRAM with
// starvation guard for debug and in-order read response steering.
// Latency: grant is combinational; read data returns RD_LAT cycles after grant.
// Backpressure: a denied requester sees *_req_ready low and must hold its
// request; the CPU additionally sees cpu_stall.
// Ports: clk, reset (sync, active-high), bus (data_sram_arb_if.slave).
module data_sram_arb
    import data_sram_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int RD_LAT     = RD_LAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    data_sram_arb_if.slave   bus
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt;
    logic                dbg_forced;
    logic                grant_cpu;
    logic                grant_dbg;
    rsp_tag_t            push_tag;
    rsp_tag_t            tail_tag;

    // Once debug has waited STARVE_MAX cycles it wins over the CPU.
    // Grants are masked during reset so nothing reaches the SRAM.
    assign dbg_forced = bus.dbg_req_valid && (starve_cnt == STARVE_LIM);
    assign grant_dbg  = !reset && bus.dbg_req_valid && (!bus.cpu_req_valid || dbg_forced);
    assign grant_cpu  = !reset && bus.cpu_req_valid && !dbg_forced;

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!bus.dbg_req_valid || grant_dbg) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign bus.cpu_req_ready = grant_cpu;
    assign bus.dbg_req_ready = grant_dbg;
    assign bus.cpu_stall     = !reset && bus.cpu_req_valid && !grant_cpu;

    assign bus.sram_en    = grant_cpu || grant_dbg;
    assign bus.sram_we    = grant_cpu ? bus.cpu_req_we :
                            grant_dbg ? bus.dbg_req_we : 4'h0;
    assign bus.sram_addr  = grant_dbg ? bus.dbg_req_addr  : bus.cpu_req_addr;
    assign bus.sram_wdata = grant_dbg ? bus.dbg_req_wdata : bus.cpu_req_wdata;

    // Only reads get a live tag; writes and idle cycles push a bubble.
    assign push_tag.valid = bus.sram_en && (bus.sram_we == 4'h0);
    assign push_tag.owner = grant_dbg ? OWN_DBG : OWN_CPU;

    rsp_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk      (clk),
        .reset    (reset),
        .push_tag (push_tag),
        .tail_tag (tail_tag)
    );

    // Slot contents are still stale in the first reset cycle, so the
    // response side is masked by reset as well.
    assign bus.cpu_rsp_valid = !reset && tail_tag.valid && (tail_tag.owner == OWN_CPU);
    assign bus.dbg_rsp_valid = !reset && tail_tag.valid && (tail_tag.owner == OWN_DBG);
    assign bus.cpu_rsp_rdata = bus.cpu_rsp_valid ? bus.sram_rdata : 32'h0;
    assign bus.dbg_rsp_rdata = bus.dbg_rsp_valid ? bus.sram_rdata : 32'h0;

endmodule

// File: tb/tb_data_sram_arb.sv
// Bench for data_sram_arb: directed stimulus, behavioural SRAM, and a
// scoreboard of expected read responses checked by an independent monitor.
// Runs with STARVE_MAX = 4 and RD_LAT = 2.
module tb_data_sram_arb;
    import data_sram_arb_pkg::*;

    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_sram_arb_if bus();

    data_sram_arb #(
        .STARVE_MAX (STARVE_MAX),
        .RD_LAT     (RD_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural SRAM ----------------
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_pipe [RD_LAT];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    always @(posedge clk) begin : sram_model
        logic [31:0] wa;
        logic [31:0] w;
        wa = {bus.sram_addr[31:2], 2'b00};
        for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= (bus.sram_en && bus.sram_we == 4'h0) ? mem_rd(wa) : 32'h0;
        if (bus.sram_en && bus.sram_we != 4'h0) begin
            w = mem_rd(wa);
            for (int b = 0; b < 4; b++)
                if (bus.sram_we[b]) w[8*b +: 8] = bus.sram_wdata[8*b +: 8];
            mem[wa] = w;
        end
    end

    assign bus.sram_rdata = rd_pipe[RD_LAT-1];

    // ---------------- scoreboard ----------------
    typedef struct {
        owner_e      owner;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];

    task automatic exp_read(input owner_e o, input logic [31:0] d);
        sb.push_back('{owner: o, data: d, due: cyc + RD_LAT});
    endtask

    always @(negedge clk) begin : monitor
        exp_t        e;
        owner_e      act_own;
        logic [31:0] act_dat;
        logic [31:0] other;
        if (bus.cpu_rsp_valid || bus.dbg_rsp_valid) begin
            checks++;
            act_own = bus.dbg_rsp_valid ? OWN_DBG : OWN_CPU;
            act_dat = bus.dbg_rsp_valid ? bus.dbg_rsp_rdata : bus.cpu_rsp_rdata;
            other   = bus.dbg_rsp_valid ? bus.cpu_rsp_rdata : bus.dbg_rsp_rdata;
            if (bus.cpu_rsp_valid && bus.dbg_rsp_valid) begin
                errors++;
                $display("FAIL rsp_onehot: cycle %0d both rsp_valid high, required exactly one", cyc);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: cycle %0d owner=%0d data=%h, required no response",
                         cyc, act_own, act_dat);
            end else begin
                e = sb.pop_front();
                if (act_own != e.owner || act_dat != e.data || cyc != e.due || other != 32'h0) begin
                    errors++;
                    $display("FAIL rsp_match: got owner=%0d data=%h cycle=%0d other_rdata=%h, required owner=%0d data=%h cycle=%0d other_rdata=0",
                             act_own, act_dat, cyc, other, e.owner, e.data, e.due);
                end
            end
        end else begin
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL rsp_missing: no response by cycle %0d, required owner=%0d data=%h at cycle %0d",
                         cyc, e.owner, e.data, e.due);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic cv, input logic [3:0] cwe, input logic [31:0] ca,
                         input logic [31:0] cwd, input logic dv, input logic [3:0] dwe,
                         input logic [31:0] da, input logic [31:0] dwd);
        bus.cpu_req_valid = cv;
        bus.cpu_req_we    = cwe;
        bus.cpu_req_addr  = ca;
        bus.cpu_req_wdata = cwd;
        bus.dbg_req_valid = dv;
        bus.dbg_req_we    = dwe;
        bus.dbg_req_addr  = da;
        bus.dbg_req_wdata = dwd;
    endtask

    task automatic drive_idle();
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // Checks grant/stall/SRAM port in the current cycle, then moves to the
    // next cycle (returns 1 time unit after the rising edge).
    task automatic cycle_check(input string name, input logic crdy, input logic drdy,
                               input logic stall, input logic [31:0] addr, input logic [3:0] we);
        logic [3:0] act;
        logic [3:0] req;
        logic       ok;
        @(negedge clk);
        checks++;
        act = {bus.cpu_req_ready, bus.dbg_req_ready, bus.cpu_stall, bus.sram_en};
        req = {crdy, drdy, stall, crdy | drdy};
        ok  = (act == req) && (bus.sram_we == ((crdy | drdy) ? we : 4'h0)) &&
              (!(crdy | drdy) || bus.sram_addr == addr);
        if (!ok) begin
            errors++;
            $display("FAIL %s: cycle %0d {crdy,drdy,stall,en}=%b we=%h addr=%h, required %b we=%h addr=%h",
                     name, cyc, act, bus.sram_we, bus.sram_addr, req, we, addr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string name, input logic [2:0] exp_cnt);
        checks++;
        if (dut.starve_cnt != exp_cnt) begin
            errors++;
            $display("FAIL %s: starve_cnt=%0d, required %0d", name, dut.starve_cnt, exp_cnt);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        mem[32'h1c000100] = 32'h11223344;
        mem[32'h00000200] = 32'h20202020;
        mem[32'h00000204] = 32'h24242424;
        mem[32'h00000300] = 32'ha0a0a0a0;
        mem[32'h00000304] = 32'hb0b0b0b0;
        mem[32'h00000308] = 32'hc0c0c0c0;

        // Reset with both requesters active: everything must stay quiet.
        reset = 1'b1;
        drive(1'b1, 4'h0, 32'h200, 32'h0, 1'b1, 4'h0, 32'h204, 32'h0);
        cycle_check("reset_quiet0", 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
        cycle_check("reset_quiet1", 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
        check_cnt("cnt_in_reset", 3'd0);

        // CPU-only read, granted in the first cycle after reset.
        reset = 1'b0;
        drive(1'b1, 4'h0, 32'h1c000100, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        exp_read(OWN_CPU, 32'h11223344);
        cycle_check("cpu_only", 1'b1, 1'b0, 1'b0, 32'h1c000100, 4'h0);
        drive_idle();
        repeat (3) cycle_check("cpu_only_idle", 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);

        // Continuous contention: 4 CPU grants then one forced debug grant.
        drive(1'b1, 4'h0, 32'h200, 32'h0, 1'b1, 4'h0, 32'h204, 32'h0);
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) begin
                exp_read(OWN_DBG, 32'h24242424);
                cycle_check("contend_dbg", 1'b0, 1'b1, 1'b1, 32'h204, 4'h0);
            end else begin
                exp_read(OWN_CPU, 32'h20202020);
                cycle_check("contend_cpu", 1'b1, 1'b0, 1'b0, 32'h200, 4'h0);
            end
        end

        // Interleaved A (CPU), B (debug, forced), C (CPU) on consecutive cycles.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 4'h0, 32'h200, 32'h0, 1'b1, 4'h0, 32'h304, 32'h0);
            exp_read(OWN_CPU, 32'h20202020);
            cycle_check("ilv_pre", 1'b1, 1'b0, 1'b0, 32'h200, 4'h0);
        end
        drive(1'b1, 4'h0, 32'h300, 32'h0, 1'b1, 4'h0, 32'h304, 32'h0);
        exp_read(OWN_CPU, 32'ha0a0a0a0);
        cycle_check("ilv_a", 1'b1, 1'b0, 1'b0, 32'h300, 4'h0);
        drive(1'b1, 4'h0, 32'h308, 32'h0, 1'b1, 4'h0, 32'h304, 32'h0);
        exp_read(OWN_DBG, 32'hb0b0b0b0);
        cycle_check("ilv_b", 1'b0, 1'b1, 1'b1, 32'h304, 4'h0);
        drive(1'b1, 4'h0, 32'h308, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        exp_read(OWN_CPU, 32'hc0c0c0c0);
        cycle_check("ilv_c", 1'b1, 1'b0, 1'b0, 32'h308, 4'h0);
        drive_idle();
        repeat (3) cycle_check("ilv_idle", 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);

        // CPU write then debug read of the same word: no bypass, no write response.
        drive(1'b1, 4'hf, 32'h100, 32'hdeadbeef, 1'b0, 4'h0, 32'h0, 32'h0);
        cycle_check("wr_cpu", 1'b1, 1'b0, 1'b0, 32'h100, 4'hf);
        drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h100, 32'h0);
        exp_read(OWN_DBG, 32'hdeadbeef);
        cycle_check("rd_dbg", 1'b0, 1'b1, 1'b0, 32'h100, 4'h0);
        drive_idle();
        repeat (3) cycle_check("wr_rd_idle", 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);

        // Debug denied 3 cycles, drops for 1, then must wait 4 more.
        drive(1'b1, 4'h0, 32'h200, 32'h0, 1'b1, 4'h0, 32'h204, 32'h0);
        for (int k = 0; k < 3; k++) begin
            exp_read(OWN_CPU, 32'h20202020);
            cycle_check("drop_pre", 1'b1, 1'b0, 1'b0, 32'h200, 4'h0);
        end
        check_cnt("cnt_pre_drop", 3'd3);
        drive(1'b1, 4'h0, 32'h200, 32'h0, 1'b0, 4'h0, 32'h204, 32'h0);
        exp_read(OWN_CPU, 32'h20202020);
        cycle_check("drop_gap", 1'b1, 1'b0, 1'b0, 32'h200, 4'h0);
        check_cnt("cnt_restart", 3'd0);
        drive(1'b1, 4'h0, 32'h200, 32'h0, 1'b1, 4'h0, 32'h204, 32'h0);
        for (int k = 0; k < 4; k++) begin
            exp_read(OWN_CPU, 32'h20202020);
            cycle_check("drop_wait", 1'b1, 1'b0, 1'b0, 32'h200, 4'h0);
        end
        exp_read(OWN_DBG, 32'h24242424);
        cycle_check("drop_grant", 1'b0, 1'b1, 1'b1, 32'h204, 4'h0);
        drive_idle();
        repeat (3) cycle_check("drop_idle", 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);

        // Reset one cycle after a CPU read grant: the read must never respond.
        drive(1'b1, 4'h0, 32'h200, 32'h0, 1'b1, 4'h0, 32'h204, 32'h0);
        cycle_check("mid_grant", 1'b1, 1'b0, 1'b0, 32'h200, 4'h0);
        reset = 1'b1;
        cycle_check("mid_reset0", 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
        cycle_check("mid_reset1", 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
        check_cnt("cnt_after_reset", 3'd0);
        reset = 1'b0;
        drive_idle();
        repeat (4) cycle_check("mid_after", 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d responses outstanding, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_sram_arb.md
DATA_SRAM_ARB -- requirements
Module: data_sram_arb

Interface
REQ-001 Parameter STARVE_MAX, default 4, is the number of consecutive cycles a debug request may be denied before it is forced a grant.
REQ-002 Parameter RD_LAT, default 1, is the data SRAM read latency in cycles, with legal range 1..3.
REQ-003 Port clk  in  1  clock; all state updates on the rising edge.
REQ-004 Port reset  in  1  reset, synchronous, active-high.
REQ-005 Port cpu_req_valid  in  1  EXE-stage memory request.
REQ-006 Port cpu_req_we  in  4  byte write enables; 0 means read.
REQ-007 Ports cpu_req_addr and cpu_req_wdata  in  32 each  CPU address and store data.
REQ-008 Port cpu_req_ready  out  1  CPU request accepted this cycle.
REQ-009 Ports dbg_req_valid (1), dbg_req_we (4), dbg_req_addr (32), dbg_req_wdata (32) are inputs carrying the debug/loader requester, same meaning as the CPU ports.
REQ-010 Port dbg_req_ready  out  1  debug request accepted this cycle.
REQ-011 Ports sram_en (1), sram_we (4), sram_addr (32), sram_wdata (32) are outputs driving the single-port data SRAM.
REQ-012 Port sram_rdata  in  32  SRAM read data, valid RD_LAT cycles after a read enable.
REQ-013 Ports cpu_rsp_valid (1) and cpu_rsp_rdata (32) are outputs returning CPU read data.
REQ-014 Ports dbg_rsp_valid (1) and dbg_rsp_rdata (32) are outputs returning debug read data.
REQ-015 Port cpu_stall  out  1  is high when cpu_req_valid is high and cpu_req_ready is low; it feeds the EXE-stage ready_go.

Function
REQ-016 At most one requester is granted per cycle; the grant is combinational from the current valids and the registered starvation counter.
REQ-017 Default priority is CPU over debug.
REQ-018 A 3-bit counter starve_cnt increments when dbg_req_valid is high and the debug request is not granted, saturating at STARVE_MAX.
REQ-019 starve_cnt clears to 0 whenever the debug requester is granted or dbg_req_valid is low.
REQ-020 When starve_cnt equals STARVE_MAX and dbg_req_valid is high, debug is granted and the CPU is denied that cycle, even if cpu_req_valid is high.
REQ-021 The granted requester's we/addr/wdata pass unchanged to the sram_* outputs, with sram_en = 1.
REQ-022 With no grant, sram_en = 0 and sram_we = 0; sram_addr and sram_wdata are don't-care.
REQ-023 Each grant with we = 0 pushes an owner tag {valid, owner} into an RD_LAT-deep shift register; writes push an invalid tag.
REQ-024 At the tail of the shift register, a valid tag asserts exactly one of cpu_rsp_valid or dbg_rsp_valid for one cycle, with the matching rdata = sram_rdata.
REQ-025 The rdata output of the non-selected requester holds 0.
REQ-026 Back-to-back reads from alternating requesters are returned in issue order, one per cycle, without bubbles.
REQ-027 Writes produce no response.
REQ-028 A write and a read to the same address on consecutive cycles follow SRAM order; no bypass is performed.
REQ-029 A request must hold its signals stable until ready; the arbiter does not latch requests.

Reset
REQ-030 While reset is high, the following are 0: starve_cnt, all tag slots, cpu_rsp_valid, dbg_rsp_valid, both rsp_rdata, sram_en, sram_we, both req_ready, and cpu_stall.
REQ-031 Reads in flight when reset asserts are discarded; no response is issued for them after reset deasserts.
REQ-032 The first grant is possible in the cycle after reset deasserts.

Structure
REQ-033 A shared package holds the owner encoding (OWN_CPU = 0, OWN_DBG = 1), the tag record type, and the STARVE_MAX/RD_LAT defaults.
REQ-034 The response tag pipeline is a sub-module rsp_tag_pipe, parameterised by RD_LAT.

Verification
REQ-035 CPU-only traffic: a CPU read to 0x1c000100 while debug is idle -> cpu_req_ready = 1 the same cycle, cpu_rsp_valid RD_LAT cycles later with the SRAM word, and cpu_stall = 0 throughout.
REQ-036 Contention: both requesters valid continuously with STARVE_MAX = 4 -> the CPU is granted 4 cycles, debug is granted in cycle 5 with cpu_stall = 1 for exactly that cycle, and the pattern repeats.
REQ-037 Interleaved reads: CPU read A, debug read B, CPU read C on consecutive cycles (forced by starvation) -> responses arrive in order A, B, C on the correct rsp ports in consecutive cycles.
REQ-038 Write then read: a CPU write of 0xdeadbeef with we = 4'hf to 0x100, then a debug read of 0x100 -> dbg_rsp_rdata = 0xdeadbeef, and no response is produced for the write.
REQ-039 Reset mid-flight: reset is asserted one cycle after a CPU read grant with RD_LAT = 2 -> no cpu_rsp_valid is seen before or after reset, and starve_cnt = 0.
REQ-040 Debug drop: debug is denied 3 cycles, then drops valid for 1 cycle, then reasserts -> starve_cnt restarts from 0, so debug waits another 4 cycles for a grant.
